// File: rtl/csla_bec_pipe.sv
// rtl/csla_bec_pipe.sv - pipelined parametrised carry-select adder/subtractor with BEC blocks
//
// Purpose: WIDTH-bit x +/- y with carry/borrow-in, built from BLK-bit carry-select
// blocks (block 0 plain RCA, the rest RCA(cin=0) + binary-to-excess-1 + mux). The
// block chain is split over STAGES register stages joined by an elastic
// valid/ready handshake.
//
// Ports:
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   in_valid / in_ready   operand beat handshake (x, y, cin, sub)
//   x, y                  operands, WIDTH bits
//   cin                   carry-in (add) or borrow-in (sub)
//   sub                   0: s = x + y + cin, 1: s = x - y - cin
//   out_valid / out_ready result beat handshake (s, cout)
//   s                     result, WIDTH bits
//   cout                  carry-out (add) or NOT borrow (sub)
//   ovf                   signed overflow, present only when CSLA_OVF_EN is defined
//
// Optional feature macro: CSLA_OVF_EN
module csla_bec_pipe #(
  parameter int WIDTH  = 32,
  parameter int BLK    = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout
`ifdef CSLA_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NB  = WIDTH / BLK;
  localparam int BPS = NB / STAGES;  // blocks handled per stage
  localparam int SW  = BPS * BLK;    // bits handled per stage

  // One carry-select block. The first block of the whole adder sees the real
  // carry-in; every other block precomputes both carry cases and selects.
  function automatic logic [BLK:0] cs_block(input logic [BLK-1:0] a,
                                            input logic [BLK-1:0] b,
                                            input logic           c,
                                            input logic           first);
    logic [BLK:0] r;
    logic [BLK:0] e;
    logic         run;
    r   = '0;
    e   = '0;
    run = 1'b0;
    if (first) begin
      r = {1'b0, a} + {1'b0, b} + {{BLK{1'b0}}, c};
      return r;
    end
    r    = {1'b0, a} + {1'b0, b};
    // BEC: e = r + 1, bit i flips when all lower bits of r are ones
    e[0] = ~r[0];
    run  = r[0];
    for (int i = 1; i <= BLK; i++) begin
      e[i] = r[i] ^ run;
      run  = run & r[i];
    end
    return c ? e : r;
  endfunction

  for (genvar j = 0; j < STAGES; j++) begin : g_st
    localparam int IW = WIDTH - j * SW;  // operand bits still unprocessed on entry
    localparam int DW = (j + 1) * SW;    // result bits finished on exit

    logic [IW-1:0] w_xi;
    logic [IW-1:0] w_bi;
    logic          w_ci;
    logic          w_vin;
    logic          w_adv;
    logic [SW-1:0] w_sum;
    logic          w_co;
    logic [BLK:0]  w_blk;
    logic          w_c;
    logic [DW-1:0] w_res_n;

    logic          r_v;
    logic [DW-1:0] r_res;
    logic          r_c;

    if (j == 0) begin : g_in
      // Subtraction is x + ~y + ~borrow; conditioning happens once, here.
      assign w_xi    = x;
      assign w_bi    = sub ? ~y : y;
      assign w_ci    = cin ^ sub;
      assign w_vin   = in_valid;
      assign w_res_n = w_sum;
    end else begin : g_mid
      assign w_xi    = g_st[j-1].g_fwd.r_x;
      assign w_bi    = g_st[j-1].g_fwd.r_b;
      assign w_ci    = g_st[j-1].r_c;
      assign w_vin   = g_st[j-1].r_v;
      assign w_res_n = {w_sum, g_st[j-1].r_res};
    end

    if (j == STAGES - 1) begin : g_last_adv
      assign w_adv = ~r_v | out_ready;
    end else begin : g_mid_adv
      assign w_adv = ~r_v | g_st[j+1].w_adv;
    end

    always_comb begin
      w_sum = '0;
      w_blk = '0;
      w_c   = w_ci;
      for (int bi = 0; bi < BPS; bi++) begin
        w_blk = cs_block(w_xi[bi*BLK +: BLK], w_bi[bi*BLK +: BLK], w_c,
                         (j == 0) && (bi == 0));
        w_sum[bi*BLK +: BLK] = w_blk[BLK-1:0];
        w_c   = w_blk[BLK];
      end
      w_co = w_c;
    end

    // Data only loads with a valid beat so a stalled or drained output holds.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_v   <= 1'b0;
        r_res <= '0;
        r_c   <= 1'b0;
      end else if (w_adv) begin
        r_v <= w_vin;
        if (w_vin) begin
          r_res <= w_res_n;
          r_c   <= w_co;
        end
      end
    end

    if (j < STAGES - 1) begin : g_fwd
      logic [IW-SW-1:0] r_x;
      logic [IW-SW-1:0] r_b;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_x <= '0;
          r_b <= '0;
        end else if (w_adv && w_vin) begin
          r_x <= w_xi[IW-1:SW];
          r_b <= w_bi[IW-1:SW];
        end
      end
    end

`ifdef CSLA_OVF_EN
    if (j == STAGES - 1) begin : g_ovf
      logic r_ovf;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_ovf <= 1'b0;
        end else if (w_adv && w_vin) begin
          r_ovf <= (w_xi[IW-1] == w_bi[IW-1]) & (w_sum[SW-1] != w_xi[IW-1]);
        end
      end
    end
`endif
  end

  assign in_ready  = g_st[0].w_adv;
  assign out_valid = g_st[STAGES-1].r_v;
  assign s         = g_st[STAGES-1].r_res;
  assign cout      = g_st[STAGES-1].r_c;
`ifdef CSLA_OVF_EN
  assign ovf       = g_st[STAGES-1].g_ovf.r_ovf;
`endif

endmodule
